// File: rtl/cordic_if.sv
// Bundle between the CORDIC sequencer, its top level, the shared add/sub unit and the atan ROM.
// CORDIC_VECTORING_EN adds the mode bit.
interface cordic_if #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
);
   logic             start;
   logic [WIDTH-1:0] x_in;
   logic [WIDTH-1:0] y_in;
   logic [WIDTH-1:0] z_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] x_out;
   logic [WIDTH-1:0] y_out;
   logic [WIDTH-1:0] z_out;
   logic [IDX_W-1:0] atan_idx;
   logic [WIDTH-1:0] atan_val;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_sub;
   logic [WIDTH-1:0] add_sum;
`ifdef CORDIC_VECTORING_EN
   logic             mode;
`endif

   modport master (
`ifdef CORDIC_VECTORING_EN
      output mode,
`endif
      output start, x_in, y_in, z_in, atan_val, add_sum,
      input  busy, done, x_out, y_out, z_out, atan_idx, add_a, add_b, add_sub
   );

   modport slave (
`ifdef CORDIC_VECTORING_EN
      input  mode,
`endif
      input  start, x_in, y_in, z_in, atan_val, add_sum,
      output busy, done, x_out, y_out, z_out, atan_idx, add_a, add_b, add_sub
   );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// Iterative CORDIC micro-sequencer sharing one external add/sub unit for the X, Y and Z updates.
// Optional CORDIC_VECTORING_EN: mode bit selects vectoring (d from y sign) instead of rotation.
//
// state  | meaning
// S_IDLE | waiting for start; adder operands parked at zero
// S_XOP  | x update, direction d decided and latched, x>>>i captured
// S_YOP  | y update using captured x>>>i
// S_ZOP  | z update with atan(2^-i); last iteration returns to idle with done
module cordic_iter_sequencer #(
   parameter int WIDTH = 32,
   parameter int ITERS = 16,
   parameter int IDX_W = 5
) (
   input  logic     clk,
   input  logic     rst,
   cordic_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_XOP, S_YOP, S_ZOP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] x_r, y_r, z_r, xsh_r;
   logic [IDX_W-1:0] i_r;
   logic             d_r;
   logic             d_now;
   logic             busy_r, done_r;
   logic             last_iter;
`ifdef CORDIC_VECTORING_EN
   logic             mode_r;
`endif

   // d encoded as 1 for +1, 0 for -1
`ifdef CORDIC_VECTORING_EN
   assign d_now = mode_r ? y_r[WIDTH-1] : ~z_r[WIDTH-1];
`else
   assign d_now = ~z_r[WIDTH-1];
`endif

   assign last_iter = (i_r == IDX_W'(ITERS - 1));

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.x_out = x_r;
   assign bus.y_out = y_r;
   assign bus.z_out = z_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.add_a    = '0;
      bus.add_b    = '0;
      bus.add_sub  = 1'b0;
      bus.atan_idx = '0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_XOP;
         end
         S_XOP: begin
            bus.add_a    = x_r;
            bus.add_b    = $signed(y_r) >>> i_r;
            bus.add_sub  = d_now;
            bus.atan_idx = i_r;
            state_nxt    = S_YOP;
         end
         S_YOP: begin
            bus.add_a    = y_r;
            bus.add_b    = xsh_r;
            bus.add_sub  = ~d_r;
            bus.atan_idx = i_r;
            state_nxt    = S_ZOP;
         end
         S_ZOP: begin
            bus.add_a    = z_r;
            bus.add_b    = bus.atan_val;
            bus.add_sub  = d_r;
            bus.atan_idx = i_r;
            state_nxt    = last_iter ? S_IDLE : S_XOP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r    <= '0;
         y_r    <= '0;
         z_r    <= '0;
         xsh_r  <= '0;
         i_r    <= '0;
         d_r    <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
`ifdef CORDIC_VECTORING_EN
         mode_r <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x_r    <= bus.x_in;
                  y_r    <= bus.y_in;
                  z_r    <= bus.z_in;
                  i_r    <= '0;
                  busy_r <= 1'b1;
`ifdef CORDIC_VECTORING_EN
                  mode_r <= bus.mode;
`endif
               end
            end
            S_XOP: begin
               d_r   <= d_now;
               xsh_r <= $signed(x_r) >>> i_r;
               x_r   <= bus.add_sum;
            end
            S_YOP: begin
               y_r <= bus.add_sum;
            end
            S_ZOP: begin
               z_r <= bus.add_sum;
               if (last_iter) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  i_r <= i_r + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
